// File: rtl/conv_pkg.sv
// Shared definitions for the convolution tap scheduler: default sizes,
// FSM state encoding and a word-select helper for packed windows.
package conv_pkg;

   localparam int unsigned CONV_DATA_WIDTH = 16;
   localparam int unsigned CONV_D          = 4;

   // Widest vector / word the word-select helper accepts
   localparam int unsigned VEC_MAX  = 1024;
   localparam int unsigned WORD_MAX = 64;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_ISSUE = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Field k of a dw*d packed vector, counted from the MSB end
   function automatic logic [WORD_MAX-1:0] word_sel(input logic [VEC_MAX-1:0] vec,
                                                    input int unsigned        dw,
                                                    input int unsigned        d,
                                                    input int unsigned        k);
      logic [VEC_MAX-1:0]  sh;
      logic [WORD_MAX-1:0] res;
      sh  = vec >> ((d - 1 - k) * dw);
      res = '0;
      for (int unsigned i = 0; i < WORD_MAX; i++) begin
         res[i] = (i < dw) ? sh[i] : 1'b0;
      end
      return res;
   endfunction

endpackage

// File: rtl/conv_tap_shifter.sv
// Image/filter window register pair. Parallel-loads both windows, presents
// word 0 (MSB field) and advances one word per shift, so the scheduler never
// needs a D-way operand mux.
module conv_tap_shifter
   import conv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = CONV_DATA_WIDTH,
   parameter int unsigned D          = CONV_D
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic                    shift,
   input  logic [DATA_WIDTH*D-1:0] image_in,
   input  logic [DATA_WIDTH*D-1:0] filter_in,
   output logic [DATA_WIDTH-1:0]   image_word,
   output logic [DATA_WIDTH-1:0]   filter_word
);

   logic [DATA_WIDTH*D-1:0] img_q;
   logic [DATA_WIDTH*D-1:0] flt_q;

   // Load has priority; a shift moves the next word into the MSB field
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         img_q <= '0;
         flt_q <= '0;
      end else if (load) begin
         img_q <= image_in;
         flt_q <= filter_in;
      end else if (shift) begin
         img_q <= img_q << DATA_WIDTH;
         flt_q <= flt_q << DATA_WIDTH;
      end
   end

   // Current head word of each window
   always_comb begin
      image_word  = DATA_WIDTH'(word_sel(VEC_MAX'(img_q), DATA_WIDTH, D, 0));
      filter_word = DATA_WIDTH'(word_sel(VEC_MAX'(flt_q), DATA_WIDTH, D, 0));
   end

endmodule

// File: rtl/conv_tap_scheduler.sv
// Sequencer for the shared float16 MAC processing element: clears the PE,
// issues one operand pair per cycle, waits out the PE latency and hands the
// dot-product result out on a valid/ready port with back-pressure.
module conv_tap_scheduler
   import conv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = CONV_DATA_WIDTH,
   parameter int unsigned D          = CONV_D,
   parameter int unsigned PE_LATENCY = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [DATA_WIDTH*D-1:0] image,
   input  logic [DATA_WIDTH*D-1:0] filter,
   output logic                    busy,
   output logic                    pe_clear,
   output logic [DATA_WIDTH-1:0]   pe_a,
   output logic [DATA_WIDTH-1:0]   pe_b,
   input  logic [DATA_WIDTH-1:0]   pe_result,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH-1:0]   out_data
);

   localparam int unsigned CNT_MAX = (D > PE_LATENCY) ? D : PE_LATENCY;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);

   state_t                  state, state_nx;
   logic [CW-1:0]           tap, tap_nx;
   logic [CW-1:0]           drain, drain_nx;
   logic                    busy_nx, clear_nx, valid_nx;
   logic [DATA_WIDTH-1:0]   a_nx, b_nx, data_nx;
   logic                    load, shift;
   logic [DATA_WIDTH-1:0]   image_word, filter_word;

   conv_tap_shifter #(
      .DATA_WIDTH (DATA_WIDTH),
      .D          (D)
   ) u_shifter (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .shift       (shift),
      .image_in    (image),
      .filter_in   (filter),
      .image_word  (image_word),
      .filter_word (filter_word)
   );

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state plus next values of every registered output. Outputs are
   // computed for the state being entered, so they line up with it.
   always_comb begin
      state_nx = state;
      tap_nx   = tap;
      drain_nx = drain;
      busy_nx  = busy;
      clear_nx = 1'b0;
      a_nx     = '0;
      b_nx     = '0;
      valid_nx = out_valid;
      data_nx  = out_data;
      load     = 1'b0;
      shift    = 1'b0;
      case (state)
         ST_IDLE: begin
            busy_nx = 1'b0;
            if (start) begin
               load     = 1'b1;
               busy_nx  = 1'b1;
               clear_nx = 1'b1;
               state_nx = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            tap_nx   = '0;
            a_nx     = image_word;
            b_nx     = filter_word;
            shift    = 1'b1;
            state_nx = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (tap == CW'(D - 1)) begin
               drain_nx = CW'(PE_LATENCY);
               state_nx = ST_DRAIN;
            end else begin
               tap_nx = tap + CW'(1);
               a_nx   = image_word;
               b_nx   = filter_word;
               shift  = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (drain == CW'(1)) begin
               drain_nx = '0;
               data_nx  = pe_result;
               valid_nx = 1'b1;
               state_nx = ST_DONE;
            end else begin
               drain_nx = drain - CW'(1);
            end
         end
         ST_DONE: begin
            if (out_valid && out_ready) begin
               valid_nx = 1'b0;
               if (start) begin
                  load     = 1'b1;
                  clear_nx = 1'b1;
                  state_nx = ST_CLEAR;
               end else begin
                  busy_nx  = 1'b0;
                  state_nx = ST_IDLE;
               end
            end
         end
         default: begin
            busy_nx  = 1'b0;
            valid_nx = 1'b0;
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Counters and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tap       <= '0;
         drain     <= '0;
         busy      <= 1'b0;
         pe_clear  <= 1'b0;
         pe_a      <= '0;
         pe_b      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         tap       <= tap_nx;
         drain     <= drain_nx;
         busy      <= busy_nx;
         pe_clear  <= clear_nx;
         pe_a      <= a_nx;
         pe_b      <= b_nx;
         out_valid <= valid_nx;
         out_data  <= data_nx;
      end
   end

endmodule

// File: tb/tb_conv_tap_scheduler.sv
// Bench for conv_tap_scheduler: a real-valued accumulator PE model with a
// two-cycle latency, directed scenarios and randomized jobs compared against
// a directly computed float16 dot product.
module tb_conv_tap_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [63:0] image, filter;
   logic        busy, pe_clear, out_valid, out_ready;
   logic [15:0] pe_a, pe_b, pe_result, out_data;

   int checks = 0;
   int errors = 0;

   conv_tap_scheduler #(
      .DATA_WIDTH (16),
      .D          (4),
      .PE_LATENCY (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .image     (image),
      .filter    (filter),
      .busy      (busy),
      .pe_clear  (pe_clear),
      .pe_a      (pe_a),
      .pe_b      (pe_b),
      .pe_result (pe_result),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   function automatic real pow2(input int n);
      real r;
      r = 1.0;
      if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
      else        for (int i = 0; i < -n; i++) r = r / 2.0;
      return r;
   endfunction

   function automatic real h2r(input logic [15:0] h);
      int  e;
      real m, r;
      e = int'(h[14:10]);
      m = real'(h[9:0]) / 1024.0;
      if (e == 0) r = m * pow2(-14);
      else        r = (1.0 + m) * pow2(e - 15);
      return h[15] ? -r : r;
   endfunction

   function automatic logic [15:0] r2h(input real v);
      real a;
      int  e, mant;
      logic s;
      if (v == 0.0) return 16'h0000;
      s = (v < 0.0);
      a = s ? -v : v;
      e = 15;
      while (a >= 2.0) begin a = a / 2.0; e++; end
      while (a < 1.0)  begin a = a * 2.0; e--; end
      mant = $rtoi((a - 1.0) * 1024.0 + 0.5);
      return {s, 5'(e), 10'(mant)};
   endfunction

   function automatic logic [15:0] wordk(input logic [63:0] v, input int k);
      return v[63 - 16*k -: 16];
   endfunction

   // Reference dot product straight from the windows
   function automatic logic [15:0] dot(input logic [63:0] img, input logic [63:0] flt);
      real s;
      s = 0.0;
      for (int k = 0; k < 4; k++) s = s + h2r(wordk(img, k)) * h2r(wordk(flt, k));
      return r2h(s);
   endfunction

   // PE model: product registered one cycle, accumulated the next
   real  s1_prod = 0.0;
   real  acc     = 0.0;
   logic s1_clr  = 1'b0;
   always @(posedge clk) begin
      s1_clr  <= pe_clear;
      s1_prod <= h2r(pe_a) * h2r(pe_b);
      if (s1_clr) acc <= 0.0;
      else        acc <= acc + s1_prod;
   end
   always_comb pe_result = r2h(acc);

   logic [15:0] tbl [8] = '{16'h0000, 16'h3C00, 16'h4000, 16'h4200,
                            16'h4400, 16'hBC00, 16'hC000, 16'h3800};

   function automatic logic [63:0] rand_win();
      logic [63:0] w;
      for (int k = 0; k < 4; k++) w[63 - 16*k -: 16] = tbl[$urandom_range(0, 7)];
      return w;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // Drive a start pulse; returns in cycle 1 (CLEAR)
   task automatic start_job(input logic [63:0] img, input logic [63:0] flt);
      start  = 1'b1;
      image  = img;
      filter = flt;
      cyc();
      start = 1'b0;
      chk("clear_pulse", 64'(pe_clear), 64'(1));
      chk("busy_clear", 64'(busy), 64'(1));
   endtask

   // From cycle 1, wait for out_valid with junk start pulses that must be ignored
   task automatic wait_valid(output int lat);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 40) begin
         start  = (lat < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
         image  = {$urandom, $urandom};
         filter = {$urandom, $urandom};
         cyc();
         lat++;
      end
      start = 1'b0;
      chk("latency", 64'(lat), 64'(8));
   endtask

   logic [63:0] img, flt;
   logic [15:0] exp_d;
   int          lat;
   logic        b2b;

   initial begin
      reset = 1'b0; start = 1'b0; out_ready = 1'b0; image = '0; filter = '0;
      #12;
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_valid", 64'(out_valid), 64'(0));
      chk("rst_data", 64'(out_data), 64'(0));
      chk("rst_pe_a", 64'(pe_a), 64'(0));
      cyc();
      reset = 1'b1;
      cyc();

      // Single directed job with cycle-by-cycle operand checks
      img = {16'h3C00, 16'h4000, 16'h4200, 16'h4400};
      flt = {4{16'h3C00}};
      start_job(img, flt);
      chk("clear_pe_a", 64'(pe_a), 64'(0));
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk("issue_pe_a", 64'(pe_a), 64'(wordk(img, k)));
         chk("issue_pe_b", 64'(pe_b), 64'(16'h3C00));
         chk("issue_clear", 64'(pe_clear), 64'(0));
      end
      for (int k = 0; k < 2; k++) begin
         cyc();
         chk("drain_pe_a", 64'(pe_a), 64'(0));
         chk("drain_valid", 64'(out_valid), 64'(0));
      end
      cyc();
      chk("job1_valid", 64'(out_valid), 64'(1));
      chk("job1_data", 64'(out_data), 64'(16'h4900));

      // Back-pressure: start ignored, result held
      for (int i = 0; i < 5; i++) begin
         start  = 1'b1;
         image  = {$urandom, $urandom};
         filter = {$urandom, $urandom};
         cyc();
         chk("bp_valid", 64'(out_valid), 64'(1));
         chk("bp_data", 64'(out_data), 64'(16'h4900));
         chk("bp_busy", 64'(busy), 64'(1));
         chk("bp_clear", 64'(pe_clear), 64'(0));
      end
      start = 1'b0;
      out_ready = 1'b1;
      cyc();
      chk("hs_valid", 64'(out_valid), 64'(0));
      chk("hs_busy", 64'(busy), 64'(0));
      out_ready = 1'b0;
      cyc();
      chk("idle_clear", 64'(pe_clear), 64'(0));

      // Back-to-back: new job accepted in the handshake cycle
      flt = {4{16'h4000}};
      start_job(img, flt);
      wait_valid(lat);
      chk("b2b_first", 64'(out_data), 64'(dot(img, flt)));
      out_ready = 1'b1;
      start     = 1'b1;
      image     = {4{16'h4000}};
      filter    = {4{16'h4000}};
      cyc();
      start = 1'b0;
      chk("b2b_clear", 64'(pe_clear), 64'(1));
      chk("b2b_valid", 64'(out_valid), 64'(0));
      chk("b2b_busy", 64'(busy), 64'(1));
      wait_valid(lat);
      chk("b2b_second", 64'(out_data), 64'(16'h4C00));
      cyc();
      out_ready = 1'b0;

      // Randomized jobs against the reference dot product
      for (int i = 0; i < 12; i++) begin
         img   = rand_win();
         flt   = rand_win();
         exp_d = dot(img, flt);
         start_job(img, flt);
         out_ready = 1'b0;
         wait_valid(lat);
         chk("rand_data", 64'(out_data), 64'(exp_d));
         out_ready = 1'b1;
         b2b = 1'($urandom_range(0, 1));
         if (!b2b) begin
            cyc();
            out_ready = 1'b0;
            chk("rand_idle_busy", 64'(busy), 64'(0));
         end
      end
      cyc();
      out_ready = 1'b0;
      cyc();

      // Mid-job reset while the third tap is on the PE
      img = {16'h4400, 16'h4200, 16'h4000, 16'h3C00};
      start_job(img, {4{16'h4000}});
      cyc(); cyc(); cyc();
      chk("pre_rst_pe_a", 64'(pe_a), 64'(16'h4000));
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_busy", 64'(busy), 64'(0));
      chk("mid_rst_pe_a", 64'(pe_a), 64'(0));
      chk("mid_rst_pe_b", 64'(pe_b), 64'(0));
      chk("mid_rst_clear", 64'(pe_clear), 64'(0));
      chk("mid_rst_valid", 64'(out_valid), 64'(0));
      chk("mid_rst_data", 64'(out_data), 64'(0));
      cyc();
      reset = 1'b1;
      cyc();
      chk("post_rst_busy", 64'(busy), 64'(0));
      start_job(rand_win(), 64'h0);
      wait_valid(lat);
      chk("post_rst_data", 64'(out_data), 64'(16'h0000));
      chk("post_rst_valid", 64'(out_valid), 64'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
